// File: rtl/sketch_match_arbiter.sv
// Pairs exact and wildcard CAM lookup results in packet order, picks the winner, and pulses wins/loses back.
// Optional winner-category counters are built when SKETCH_MATCH_ARBITER_STATS_EN is defined.

module sketch_match_arbiter_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             avail,
    output logic             overflow_set
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  empty;
    logic                  full;
    logic                  wr;
    logic                  rd;

    assign empty = (count == '0);
    assign full  = (count == (DEPTH_BITS+1)'(DEPTH));

    // An empty FIFO exposes the incoming strobe directly so a pair can be decided in its arrival cycle.
    assign head  = empty ? push_data : mem[rd_ptr];
    assign avail = !empty || push_vld;

    assign rd           = pop && !empty;
    assign wr           = push_vld && (!full || pop) && !(empty && pop);
    assign overflow_set = push_vld && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_BITS+1)'(wr) - (DEPTH_BITS+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end
endmodule

module sketch_match_arbiter #(
    parameter int                      ACTION_WIDTH    = 32,
    parameter int                      FIFO_DEPTH_BITS = 3,
    parameter logic [ACTION_WIDTH-1:0] MISS_ACTION     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exact_hit,
    input  logic [ACTION_WIDTH-1:0] exact_data,
    input  logic                    exact_data_vld,
    input  logic                    wildcard_hit,
    input  logic [ACTION_WIDTH-1:0] wildcard_data,
    input  logic                    wildcard_data_vld,
    output logic                    exact_wins,
    output logic                    exact_loses,
    output logic                    wildcard_wins,
    output logic                    wildcard_loses,
    output logic                    result_vld,
    input  logic                    result_rdy,
    output logic                    result_hit,
    output logic                    result_src,
    output logic [ACTION_WIDTH-1:0] result_data,
    output logic                    overflow_err,
    output logic [31:0]             stat_exact,
    output logic [31:0]             stat_wild,
    output logic [31:0]             stat_miss
);
    logic [ACTION_WIDTH:0] exact_head;
    logic [ACTION_WIDTH:0] wild_head;
    logic                  exact_avail;
    logic                  wild_avail;
    logic                  exact_ovf;
    logic                  wild_ovf;
    logic                  decide;

    assign decide = exact_avail && wild_avail && (!result_vld || result_rdy);

    sketch_match_arbiter_fifo #(
        .WIDTH      (ACTION_WIDTH + 1),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_exact_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_vld     (exact_data_vld),
        .push_data    ({exact_hit, exact_data}),
        .pop          (decide),
        .head         (exact_head),
        .avail        (exact_avail),
        .overflow_set (exact_ovf)
    );

    sketch_match_arbiter_fifo #(
        .WIDTH      (ACTION_WIDTH + 1),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_wild_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_vld     (wildcard_data_vld),
        .push_data    ({wildcard_hit, wildcard_data}),
        .pop          (decide),
        .head         (wild_head),
        .avail        (wild_avail),
        .overflow_set (wild_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_vld     <= 1'b0;
            result_hit     <= 1'b0;
            result_src     <= 1'b0;
            result_data    <= '0;
            exact_wins     <= 1'b0;
            exact_loses    <= 1'b0;
            wildcard_wins  <= 1'b0;
            wildcard_loses <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            exact_wins     <= 1'b0;
            exact_loses    <= 1'b0;
            wildcard_wins  <= 1'b0;
            wildcard_loses <= 1'b0;
            if (exact_ovf || wild_ovf) overflow_err <= 1'b1;
            if (decide) begin
                result_vld <= 1'b1;
                if (exact_head[ACTION_WIDTH]) begin
                    result_hit     <= 1'b1;
                    result_src     <= 1'b0;
                    result_data    <= exact_head[ACTION_WIDTH-1:0];
                    exact_wins     <= 1'b1;
                    wildcard_loses <= 1'b1;
                end else if (wild_head[ACTION_WIDTH]) begin
                    result_hit     <= 1'b1;
                    result_src     <= 1'b1;
                    result_data    <= wild_head[ACTION_WIDTH-1:0];
                    wildcard_wins  <= 1'b1;
                    exact_loses    <= 1'b1;
                end else begin
                    result_hit     <= 1'b0;
                    result_src     <= 1'b0;
                    result_data    <= MISS_ACTION;
                    exact_loses    <= 1'b1;
                    wildcard_loses <= 1'b1;
                end
            end else if (result_rdy) begin
                result_vld <= 1'b0;
            end
        end
    end

`ifdef SKETCH_MATCH_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_exact <= '0;
            stat_wild  <= '0;
            stat_miss  <= '0;
        end else if (decide) begin
            if (exact_head[ACTION_WIDTH]) begin
                if (stat_exact != 32'hFFFF_FFFF) stat_exact <= stat_exact + 32'd1;
            end else if (wild_head[ACTION_WIDTH]) begin
                if (stat_wild != 32'hFFFF_FFFF) stat_wild <= stat_wild + 32'd1;
            end else begin
                if (stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
            end
        end
    end
`else
    assign stat_exact = '0;
    assign stat_wild  = '0;
    assign stat_miss  = '0;
`endif
endmodule

// File: tb/tb_sketch_match_arbiter.sv
// Self-checking bench for sketch_match_arbiter: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.

module tb_sketch_match_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          exact_hit, exact_data_vld;
    logic [AW-1:0] exact_data;
    logic          wildcard_hit, wildcard_data_vld;
    logic [AW-1:0] wildcard_data;
    logic          exact_wins, exact_loses, wildcard_wins, wildcard_loses;
    logic          result_vld, result_rdy, result_hit, result_src;
    logic [AW-1:0] result_data;
    logic          overflow_err;
    logic [31:0]   stat_exact, stat_wild, stat_miss;

    sketch_match_arbiter #(
        .ACTION_WIDTH    (AW),
        .FIFO_DEPTH_BITS (3),
        .MISS_ACTION     ('0)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .exact_hit         (exact_hit),
        .exact_data        (exact_data),
        .exact_data_vld    (exact_data_vld),
        .wildcard_hit      (wildcard_hit),
        .wildcard_data     (wildcard_data),
        .wildcard_data_vld (wildcard_data_vld),
        .exact_wins        (exact_wins),
        .exact_loses       (exact_loses),
        .wildcard_wins     (wildcard_wins),
        .wildcard_loses    (wildcard_loses),
        .result_vld        (result_vld),
        .result_rdy        (result_rdy),
        .result_hit        (result_hit),
        .result_src        (result_src),
        .result_data       (result_data),
        .overflow_err      (overflow_err),
        .stat_exact        (stat_exact),
        .stat_wild         (stat_wild),
        .stat_miss         (stat_miss)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: packet queues plus the visible result state.
    logic [AW:0]   qe[$];
    logic [AW:0]   qw[$];
    logic          m_vld, m_hit, m_src, m_ovf;
    logic [AW-1:0] m_data;
    logic [3:0]    m_pulse;
    int unsigned   ms_e, ms_w, ms_m;

    typedef struct {
        logic          e_vld, e_hit;
        logic [AW-1:0] e_data;
        logic          w_vld, w_hit;
        logic [AW-1:0] w_data;
        logic          rdy;
        logic          x_vld, x_hit, x_src;
        logic [AW-1:0] x_data;
        logic [3:0]    x_pulse;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qe.delete();
        qw.delete();
        m_vld = 0; m_hit = 0; m_src = 0; m_ovf = 0; m_data = '0; m_pulse = '0;
        ms_e = 0; ms_w = 0; ms_m = 0;
    endtask

    task automatic model_tick();
        bit          dec;
        logic [AW:0] he, hw;
        dec = (qe.size() > 0 || exact_data_vld) && (qw.size() > 0 || wildcard_data_vld)
              && (!m_vld || result_rdy);
        if (exact_data_vld) begin
            if (qe.size() < 8 || dec) qe.push_back({exact_hit, exact_data});
            else m_ovf = 1;
        end
        if (wildcard_data_vld) begin
            if (qw.size() < 8 || dec) qw.push_back({wildcard_hit, wildcard_data});
            else m_ovf = 1;
        end
        m_pulse = '0;
        if (dec) begin
            he = qe.pop_front();
            hw = qw.pop_front();
            m_vld = 1;
            if (he[AW]) begin
                m_hit = 1; m_src = 0; m_data = he[AW-1:0]; m_pulse = 4'b1001;
                if (ms_e != 32'hFFFF_FFFF) ms_e++;
            end else if (hw[AW]) begin
                m_hit = 1; m_src = 1; m_data = hw[AW-1:0]; m_pulse = 4'b0110;
                if (ms_w != 32'hFFFF_FFFF) ms_w++;
            end else begin
                m_hit = 0; m_src = 0; m_data = '0; m_pulse = 4'b0101;
                if (ms_m != 32'hFFFF_FFFF) ms_m++;
            end
        end else if (result_rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic compare_all();
        logic [95:0] exp_stats;
`ifdef SKETCH_MATCH_ARBITER_STATS_EN
        exp_stats = {ms_e, ms_w, ms_m};
`else
        exp_stats = '0;
`endif
        check("result", {result_vld, result_hit, result_src, result_data},
              {m_vld, m_hit, m_src, m_data});
        check("pulses", {exact_wins, exact_loses, wildcard_wins, wildcard_loses}, m_pulse);
        check("overflow", overflow_err, m_ovf);
        check("stats", {stat_exact, stat_wild, stat_miss}, exp_stats);
    endtask

    task automatic drive(input logic ev, input logic eh, input logic [AW-1:0] ed,
                         input logic wv, input logic wh, input logic [AW-1:0] wd, input logic rdy);
        exact_data_vld = ev; exact_hit = eh; exact_data = ed;
        wildcard_data_vld = wv; wildcard_hit = wh; wildcard_data = wd;
        result_rdy = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0, 0, '0, 1);
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        logic [95:0] stat_exp;

        vecs[0] = '{1, 1, 32'hA5, 1, 1, 32'h3C, 1, 1, 1, 0, 32'hA5, 4'b1001};
        vecs[1] = '{1, 0, 32'h11, 1, 1, 32'h77, 1, 1, 1, 1, 32'h77, 4'b0110};
        vecs[2] = '{1, 0, 32'h22, 1, 0, 32'h33, 1, 1, 0, 0, 32'h00, 4'b0101};
        vecs[3] = '{0, 0, 32'h00, 0, 0, 32'h00, 1, 0, 0, 0, 32'h00, 4'b0000};
        vecs[4] = '{1, 1, 32'h05, 0, 0, 32'h00, 1, 0, 0, 0, 32'h00, 4'b0000};
        vecs[5] = '{0, 0, 32'h00, 1, 1, 32'h06, 0, 1, 1, 0, 32'h05, 4'b1001};
        vecs[6] = '{0, 0, 32'h00, 0, 0, 32'h00, 0, 1, 1, 0, 32'h05, 4'b0000};
        vecs[7] = '{0, 0, 32'h00, 0, 0, 32'h00, 1, 0, 1, 0, 32'h05, 4'b0000};

        do_reset();

        // Directed vectors: selection rules, latency, hold and release.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].e_vld, vecs[i].e_hit, vecs[i].e_data,
                  vecs[i].w_vld, vecs[i].w_hit, vecs[i].w_data, vecs[i].rdy);
            step();
            check($sformatf("vec%0d_result", i), {result_vld, result_hit, result_src, result_data},
                  {vecs[i].x_vld, vecs[i].x_hit, vecs[i].x_src, vecs[i].x_data});
            check($sformatf("vec%0d_pulses", i),
                  {exact_wins, exact_loses, wildcard_wins, wildcard_loses}, vecs[i].x_pulse);
        end
`ifdef SKETCH_MATCH_ARBITER_STATS_EN
        stat_exp = {32'd2, 32'd1, 32'd1};
`else
        stat_exp = '0;
`endif
        check("stats_after_vectors", {stat_exact, stat_wild, stat_miss}, stat_exp);

        // Exact side runs ahead; nothing may be emitted until the wildcard side arrives.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h100 + i, 0, 0, '0, 1);
            step();
            check("no_early_vld", result_vld, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, '0, 0, 0, '0, 1);
            step();
            check("no_early_vld", result_vld, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1, 0, 32'h900 + i, 1);
            step();
            check("order_data", result_data, 32'h100 + i);
        end
        drive(0, 0, '0, 0, 0, '0, 1);
        repeat (2) step();

        // Stall: one result held, then 9 strobes per source; the 9th overflows.
        do_reset();
        drive(1, 1, 32'h200, 1, 0, 32'h201, 0);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1, i[0], 32'h300 + i, 1, 1, 32'h400 + i, 0);
            step();
            check("held_data", result_data, 32'h200);
        end
        check("overflow_set", overflow_err, 1'b1);
        drive(0, 0, '0, 0, 0, '0, 1);
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (result_vld && result_rdy) n_acc++;
            step();
        end
        check("drain_count", n_acc, 9);

        // Reset with entries buffered, then a fresh pair.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h500 + i, 0, 0, '0, 1);
            step();
        end
        do_reset();
        check("reset_outputs", {result_vld, exact_wins, exact_loses, wildcard_wins, wildcard_loses,
              overflow_err, result_data}, '0);
        drive(1, 1, 32'hAB, 1, 1, 32'hCD, 1);
        step();
        check("post_reset_pair", {result_vld, result_src, result_data}, {1'b1, 1'b0, 32'hAB});
        drive(0, 0, '0, 0, 0, '0, 1);
        repeat (2) step();

        // Random traffic against the model, with bursts of back-pressure.
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            rdy = ((i / 200) % 3 == 2) ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 75);
            drive($urandom_range(0, 99) < 45, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 1), $urandom, rdy);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
